// File: rtl/frame_render_ctrl.sv
// Per-frame sequencer: rewind list, clear back buffer, project + rasterize, swap, advance angle.
// Latency: sync edge to list_rewind 1 cycle; minimum frame 6 cycles from REWIND back to IDLE.
// Backpressure: each phase waits on its engine's done handshake; a per-state watchdog aborts a stuck frame.
module frame_render_ctrl #(
  parameter int WIIA = 4,
  parameter int WIFA = 8,
  parameter logic [WIIA+WIFA-1:0] ANGLE_STEP = 12'h010,
  parameter logic [WIIA+WIFA-1:0] ANGLE_MAX  = 12'h648,
  parameter int TRI_CNT_W = 10,
  parameter int TIMEOUT_W = 20
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   enable,
  input  logic                   pause,
  input  logic                   frame_sync,
  output logic                   proj_start,
  input  logic                   proj_done,
  input  logic                   fifo_w_mon,
  output logic                   list_rewind,
  output logic                   clear_start,
  input  logic                   clear_done,
  output logic                   draw_start,
  input  logic                   draw_done,
  input  logic                   fifo_empty,
  output logic [WIIA+WIFA-1:0]   angle,
  output logic                   buf_swap,
  output logic                   frame_busy,
  output logic [TRI_CNT_W-1:0]   tri_count,
  output logic                   overrun,
  output logic                   timeout
);

  localparam int AW = WIIA + WIFA;
  localparam logic [TRI_CNT_W-1:0] CNT_ONE = {{(TRI_CNT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] WD_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REWIND   = 3'd1,
    CLEAR    = 3'd2,
    PROJ     = 3'd3,
    PROJ_END = 3'd4,
    DRAIN    = 3'd5,
    SWAP     = 3'd6
  } state_t;

  state_t               state;
  logic                 frame_sync_q;
  logic                 sync_edge;
  logic [TRI_CNT_W-1:0] frame_cnt;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic                 wd_run;
  logic                 wd_expired;
  logic                 cnt_en;
  logic [AW:0]          angle_sum;
  logic [AW-1:0]        angle_next;

  // frame_sync is already in the Clk domain, so a single delay flop gives the edge
  assign sync_edge  = frame_sync & ~frame_sync_q;
  // The watchdog only runs in states that wait on an external engine
  assign wd_run     = (state == CLEAR) || (state == PROJ) || (state == PROJ_END) || (state == DRAIN);
  assign wd_expired = wd_run && (&wd_cnt);
  // Triangles are counted as long as the projection engine may still be writing
  assign cnt_en     = (state == PROJ) || (state == PROJ_END);

  // Next angle: sum is one bit wider so the wrap compare cannot overflow
  always_comb begin
    angle_sum = {1'b0, angle} + {1'b0, ANGLE_STEP};
    if (angle_sum >= {1'b0, ANGLE_MAX}) angle_next = angle_sum[AW-1:0] - ANGLE_MAX;
    else                                angle_next = angle_sum[AW-1:0];
  end

  // Frame sequencer: state, counters and all registered outputs
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state        <= IDLE;
      frame_sync_q <= 1'b0;
      frame_cnt    <= '0;
      wd_cnt       <= '0;
      proj_start   <= 1'b0;
      list_rewind  <= 1'b0;
      clear_start  <= 1'b0;
      draw_start   <= 1'b0;
      buf_swap     <= 1'b0;
      frame_busy   <= 1'b0;
      angle        <= '0;
      tri_count    <= '0;
      overrun      <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      frame_sync_q <= frame_sync;
      list_rewind  <= 1'b0;
      buf_swap     <= 1'b0;

      // A new sync while a frame is in flight is dropped and flagged
      if (sync_edge && (state != IDLE)) overrun <= 1'b1;

      // Saturating per-frame triangle count; a write coincident with proj_done still counts
      if (cnt_en && fifo_w_mon && !(&frame_cnt)) frame_cnt <= frame_cnt + CNT_ONE;

      // Default watchdog behaviour; every state change below clears it explicitly
      wd_cnt <= wd_run ? (wd_cnt + WD_ONE) : '0;

      if (wd_expired) begin
        // Abort: drop all starts, no swap, angle and tri_count untouched
        timeout     <= 1'b1;
        state       <= IDLE;
        clear_start <= 1'b0;
        proj_start  <= 1'b0;
        draw_start  <= 1'b0;
        frame_busy  <= 1'b0;
        wd_cnt      <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!enable) begin
              overrun <= 1'b0;
              timeout <= 1'b0;
            end else if (sync_edge) begin
              state       <= REWIND;
              list_rewind <= 1'b1;
              frame_busy  <= 1'b1;
            end
          end
          REWIND: begin
            frame_cnt   <= '0;
            state       <= CLEAR;
            clear_start <= 1'b1;
            wd_cnt      <= '0;
          end
          CLEAR: begin
            if (clear_done) begin
              state       <= PROJ;
              clear_start <= 1'b0;
              proj_start  <= 1'b1;
              draw_start  <= 1'b1;
              wd_cnt      <= '0;
            end
          end
          PROJ: begin
            if (proj_done) begin
              state      <= PROJ_END;
              proj_start <= 1'b0;
              wd_cnt     <= '0;
            end
          end
          PROJ_END: begin
            if (!proj_done) begin
              state  <= DRAIN;
              wd_cnt <= '0;
            end
          end
          DRAIN: begin
            if (fifo_empty && draw_done) begin
              state      <= SWAP;
              draw_start <= 1'b0;
              buf_swap   <= 1'b1;
              tri_count  <= frame_cnt;
              if (!pause) angle <= angle_next;
              wd_cnt     <= '0;
            end
          end
          SWAP: begin
            state      <= IDLE;
            frame_busy <= 1'b0;
          end
          default: begin
            state       <= IDLE;
            clear_start <= 1'b0;
            proj_start  <= 1'b0;
            draw_start  <= 1'b0;
            frame_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_frame_render_ctrl.sv
// Scoreboard bench for frame_render_ctrl with a behavioural angle / triangle-count model.
// Latency: engines are emulated reactively with random delays per phase.
// Backpressure: every wait on the DUT is bounded; an expired bound is reported as a failed check.
module tb_frame_render_ctrl;

  localparam int TRI_W  = 3;
  localparam int TO_W   = 5;
  localparam int STEP   = 16;
  localparam int AMAX   = 1608;
  localparam int TRIMAX = (1 << TRI_W) - 1;

  logic             Clk = 1'b0;
  logic             Reset_n;
  logic             enable, pause, frame_sync;
  logic             proj_start, proj_done, fifo_w_mon, list_rewind;
  logic             clear_start, clear_done, draw_start, draw_done, fifo_empty;
  logic [11:0]      angle;
  logic             buf_swap, frame_busy, overrun, timeout;
  logic [TRI_W-1:0] tri_count;

  frame_render_ctrl #(
    .WIIA(4), .WIFA(8), .ANGLE_STEP(12'h010), .ANGLE_MAX(12'h648),
    .TRI_CNT_W(TRI_W), .TIMEOUT_W(TO_W)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .enable(enable), .pause(pause), .frame_sync(frame_sync),
    .proj_start(proj_start), .proj_done(proj_done), .fifo_w_mon(fifo_w_mon),
    .list_rewind(list_rewind), .clear_start(clear_start), .clear_done(clear_done),
    .draw_start(draw_start), .draw_done(draw_done), .fifo_empty(fifo_empty),
    .angle(angle), .buf_swap(buf_swap), .frame_busy(frame_busy), .tri_count(tri_count),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int ntri;
    int ang;
  } rec_t;

  rec_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   swaps = 0;
  int   rewinds = 0;
  int   model_angle = 0;
  int   cur_start = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return clear_start;
      1:       return proj_start;
      2:       return frame_busy;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int which, input logic val, input string name);
    int n;
    n = 0;
    while (sig(which) !== val && n < 200) begin
      tick(1);
      n++;
    end
    chk(name, int'(sig(which)), int'(val));
  endtask

  // Reference model: angle advances by STEP and wraps at AMAX; count saturates
  function automatic int next_angle(input int a);
    return (a + STEP >= AMAX) ? (a + STEP - AMAX) : (a + STEP);
  endfunction

  // mode 0 normal, 1 inject a sync edge during projection, 2 drop enable mid-frame
  task automatic do_frame(input int nw, input logic pse, input int mode);
    rec_t r;
    cur_start = model_angle;
    if (!pse) model_angle = next_angle(model_angle);
    r.ang  = model_angle;
    r.ntri = (nw > TRIMAX) ? TRIMAX : nw;
    sb_q.push_back(r);
    pause = pse; fifo_empty = 1'b0; draw_done = 1'b0;
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
    wait_sig(0, 1'b1, "clear_start_rise");
    tick($urandom_range(0, 6));
    clear_done = 1'b1;
    tick(1);
    clear_done = 1'b0;
    wait_sig(1, 1'b1, "proj_start_rise");
    if (mode == 2) enable = 1'b0;
    for (int i = 0; i < nw; i++) begin
      fifo_w_mon = 1'b1;
      if (i == nw - 1 && $urandom_range(0, 1) == 1) proj_done = 1'b1;
      tick(1);
      fifo_w_mon = 1'b0;
      tick($urandom_range(0, 1));
    end
    if (mode == 1) begin
      frame_sync = 1'b1;
      tick(1);
      frame_sync = 1'b0;
    end
    proj_done = 1'b1;
    wait_sig(1, 1'b0, "proj_start_fall");
    tick($urandom_range(0, 3));
    proj_done = 1'b0;
    tick($urandom_range(0, 4));
    fifo_empty = 1'b1; draw_done = 1'b1;
    wait_sig(2, 1'b0, "frame_end");
    pause = 1'b0;
  endtask

  // Monitor: angle must be stable at rewind; each swap pops one expected frame
  always @(negedge Clk) begin
    if (Reset_n) begin
      if (list_rewind) begin
        rewinds++;
        chk("angle_at_rewind", int'(angle), cur_start);
      end
      if (buf_swap) begin
        swaps++;
        if (sb_q.size() == 0) chk("unexpected_swap", 1, 0);
        else begin
          rec_t r;
          r = sb_q.pop_front();
          chk("swap_tri_count", int'(tri_count), r.ntri);
          chk("swap_angle", int'(angle), r.ang);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, limit 1000000 ns");
    $fatal(1);
  end

  initial begin
    int r0, s0, n;
    Reset_n = 1'b0; enable = 1'b0; pause = 1'b0; frame_sync = 1'b0;
    proj_done = 1'b0; fifo_w_mon = 1'b0; clear_done = 1'b0;
    draw_done = 1'b1; fifo_empty = 1'b1;
    tick(3);
    chk("rst_busy", int'(frame_busy), 0);
    chk("rst_starts", int'({proj_start, clear_start, draw_start, list_rewind, buf_swap}), 0);
    chk("rst_angle", int'(angle), 0);
    chk("rst_flags", int'({tri_count, overrun, timeout}), 0);
    Reset_n = 1'b1; enable = 1'b1;
    tick(2);

    // Basic frame
    do_frame(3, 1'b0, 0);
    chk("basic_tri", int'(tri_count), 3);
    chk("basic_angle", int'(angle), 'h010);
    chk("basic_swaps", swaps, 1);
    chk("basic_rewinds", rewinds, 1);

    // Run up to the angle wrap: frame 101 takes 0x640 to 0x008
    for (int f = 2; f <= 101; f++) do_frame($urandom_range(0, 5), 1'b0, 0);
    chk("wrap_angle", int'(angle), 'h008);

    // Paused frame keeps the angle
    do_frame(2, 1'b1, 0);
    chk("pause_angle", int'(angle), 'h008);

    // Overrun during projection
    r0 = rewinds; s0 = swaps;
    do_frame(4, 1'b0, 1);
    chk("overrun_set", int'(overrun), 1);
    chk("overrun_rewinds", rewinds - r0, 1);
    chk("overrun_swaps", swaps - s0, 1);
    enable = 1'b0;
    tick(2);
    chk("overrun_clear", int'(overrun), 0);
    enable = 1'b1;

    // Saturating triangle count
    do_frame(10, 1'b0, 0);
    chk("sat_tri", int'(tri_count), TRIMAX);

    // enable dropped mid-frame: frame finishes, next sync ignored
    do_frame(2, 1'b0, 2);
    r0 = rewinds;
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
    tick(3);
    chk("disabled_busy", int'(frame_busy), 0);
    chk("disabled_rewinds", rewinds - r0, 0);
    enable = 1'b1;
    tick(1);

    // Random frames
    for (int f = 0; f < 20; f++) do_frame($urandom_range(0, 9), logic'($urandom_range(0, 1)), 0);

    // Watchdog: clear_done never arrives
    s0 = swaps;
    cur_start = model_angle;
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
    wait_sig(0, 1'b1, "wd_clear_start");
    n = 0;
    while (frame_busy && n < 200) begin
      tick(1);
      n++;
    end
    chk("wd_busy", int'(frame_busy), 0);
    chk("wd_len_ok", int'(n >= (1 << TO_W) - 2 && n <= (1 << TO_W) + 1), 1);
    chk("wd_timeout", int'(timeout), 1);
    chk("wd_clear_start", int'(clear_start), 0);
    chk("wd_angle", int'(angle), model_angle);
    chk("wd_no_swap", swaps - s0, 0);
    enable = 1'b0;
    tick(2);
    chk("wd_timeout_clear", int'(timeout), 0);
    enable = 1'b1;

    // Asynchronous reset in the middle of projection
    cur_start = model_angle;
    frame_sync = 1'b1;
    tick(1);
    frame_sync = 1'b0;
    wait_sig(0, 1'b1, "ar_clear_start");
    clear_done = 1'b1;
    tick(1);
    clear_done = 1'b0;
    wait_sig(1, 1'b1, "ar_proj_start");
    #3;
    Reset_n = 1'b0;
    #1;
    chk("ar_proj_start", int'(proj_start), 0);
    chk("ar_draw_start", int'(draw_start), 0);
    chk("ar_busy", int'(frame_busy), 0);
    chk("ar_angle", int'(angle), 0);
    model_angle = 0;
    tick(2);
    Reset_n = 1'b1;
    tick(1);
    chk("ar_tri_count", int'(tri_count), 0);

    do_frame(1, 1'b0, 0);
    chk("post_reset_angle", int'(angle), 'h010);
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
